// File: rtl/hdmi_link_decoder_pkg.sv
// Shared HDMI link definitions: link-period states, control/guard symbols and
// the TMDS/TERC4 symbol coders used by the transmitter and the receive decoder.
package hdmi_link_decoder_pkg;

    typedef enum logic [2:0] {
        CONTROL        = 3'd0,
        VIDEO_PREAMBLE = 3'd1,
        VIDEO_GUARD    = 3'd2,
        VIDEO_ISLAND   = 3'd3,
        AUXIL_PREAMBLE = 3'd4,
        AUXIL_GUARD    = 3'd5,
        AUXIL_ISLAND   = 3'd6
    } STATE_t;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    localparam logic [9:0] VIDEO_GUARD_CH02  = 10'b1011001100;
    localparam logic [9:0] VIDEO_GUARD_CH1   = 10'b0100110011;
    localparam logic [9:0] ISLAND_GUARD_CH12 = 10'b0100110011;

    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
    localparam logic [3:0] CTL_AUXIL_PREAMBLE = 4'b0101;

    function automatic logic [9:0] TERC4Encoder(input logic [3:0] d);
        case (d)
            4'h0: return 10'b1010011100;
            4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;
            4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;
            4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;
            4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;
            4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;
            4'hB: return 10'b1011000110;
            4'hC: return 10'b1010001110;
            4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    // Returns {member, nibble}; searching the encoder keeps the two tables in lockstep.
    function automatic logic [4:0] TERC4Decoder(input logic [9:0] q);
        logic [4:0] r;
        r = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (TERC4Encoder(4'(i)) == q) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    function automatic logic [7:0] TMDSDecoder(input logic [9:0] q);
        logic [7:0] b;
        logic [7:0] d;
        b = q[9] ? ~q[7:0] : q[7:0];
        d[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/hdmi_symbol_classifier.sv
// Per-channel combinational symbol classifier: flags control tokens, guard
// bands and TERC4 membership, and offers every candidate decoding of the symbol.
module hdmi_symbol_classifier
    import hdmi_link_decoder_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic [9:0] symbol,
    output logic       is_control,
    output logic [1:0] ctl_code,
    output logic       is_video_guard,
    output logic       is_island_guard,
    output logic       is_terc4,
    output logic [3:0] terc4_data,
    output logic [7:0] tmds_data
);
    logic [4:0] terc4_dec;

    always_comb begin
        is_control = 1'b1;
        ctl_code   = 2'b00;
        case (symbol)
            CTRL_TOKEN_00: ctl_code = 2'b00;
            CTRL_TOKEN_01: ctl_code = 2'b01;
            CTRL_TOKEN_10: ctl_code = 2'b10;
            CTRL_TOKEN_11: ctl_code = 2'b11;
            default:       is_control = 1'b0;
        endcase
    end

    assign terc4_dec  = TERC4Decoder(symbol);
    assign is_terc4   = terc4_dec[4];
    assign terc4_data = terc4_dec[3:0];
    assign tmds_data  = TMDSDecoder(symbol);

    generate
        if (CHANNEL == 1) begin : g_vguard_ch1
            assign is_video_guard = (symbol == VIDEO_GUARD_CH1);
        end else begin : g_vguard_ch02
            assign is_video_guard = (symbol == VIDEO_GUARD_CH02);
        end
        // Channel 0 island guards still carry HSYNC/VSYNC, so any TERC4 4'b11xx qualifies.
        if (CHANNEL == 0) begin : g_iguard_ch0
            assign is_island_guard = is_terc4 && (terc4_data[3:2] == 2'b11);
        end else begin : g_iguard_ch12
            assign is_island_guard = (symbol == ISLAND_GUARD_CH12);
        end
    endgenerate

endmodule

// File: rtl/hdmi_link_decoder.sv
// Receive-side HDMI link decoder: tracks the link period and decodes each TMDS
// channel as control, video or TERC4 data. HDMI_DECODER_ERROR_COUNT_EN adds errorCount.
module hdmi_link_decoder
    import hdmi_link_decoder_pkg::*;
#(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int PACKET_LEN   = 32,
    parameter int MAX_PACKETS  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        symbolValid,
    input  logic [9:0]  symbol0,
    input  logic [9:0]  symbol1,
    input  logic [9:0]  symbol2,
    output STATE_t      state,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  ctl,
    output logic [23:0] videoData,
    output logic        videoValid,
    output logic [11:0] auxData,
    output logic        auxValid,
    output logic        packetStart,
    output logic        protocolError
`ifdef HDMI_DECODER_ERROR_COUNT_EN
    ,
    output logic [15:0] errorCount
`endif
);
    localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam int GRD_W = $clog2(GUARD_LEN + 1);
    localparam int ISL_W = $clog2(MAX_PACKETS * PACKET_LEN + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_LEN);
    localparam logic [ISL_W-1:0] PKT_C    = ISL_W'(PACKET_LEN);
    localparam logic [ISL_W-1:0] ISL_MAX  = ISL_W'(MAX_PACKETS * PACKET_LEN);

    logic [9:0] sym [3];
    logic       is_control [3];
    logic [1:0] ctl_code [3];
    logic       is_video_guard [3];
    logic       is_island_guard [3];
    logic       is_terc4 [3];
    logic [3:0] terc4_data [3];
    logic [7:0] tmds_data [3];

    assign sym[0] = symbol0;
    assign sym[1] = symbol1;
    assign sym[2] = symbol2;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            hdmi_symbol_classifier #(.CHANNEL(gi)) u_classifier (
                .symbol          (sym[gi]),
                .is_control      (is_control[gi]),
                .ctl_code        (ctl_code[gi]),
                .is_video_guard  (is_video_guard[gi]),
                .is_island_guard (is_island_guard[gi]),
                .is_terc4        (is_terc4[gi]),
                .terc4_data      (terc4_data[gi]),
                .tmds_data       (tmds_data[gi])
            );
        end
    endgenerate

    logic [PRE_W-1:0] pre_cnt_reg;
    logic [3:0]       pre_pattern_reg;
    logic [GRD_W-1:0] guard_cnt_reg;
    logic [ISL_W-1:0] island_cnt_reg;
    logic             trailing_reg;

    logic             all_ctl, any_ctl, all_vguard, all_iguard, trail_guard, terc4_ok;
    logic             is_preamble, island_bad, video_pre_done;
    logic [3:0]       ctl_val;
    logic [PRE_W-1:0] pre_cnt_next;
    logic [GRD_W-1:0] guard_cnt_next;

    assign all_ctl     = is_control[0] & is_control[1] & is_control[2];
    assign any_ctl     = is_control[0] | is_control[1] | is_control[2];
    assign all_vguard  = is_video_guard[0] & is_video_guard[1] & is_video_guard[2];
    assign all_iguard  = is_island_guard[0] & is_island_guard[1] & is_island_guard[2];
    assign trail_guard = is_island_guard[1] & is_island_guard[2];
    assign terc4_ok    = is_terc4[0] & is_terc4[1] & is_terc4[2];
    assign ctl_val     = {ctl_code[2], ctl_code[1]};
    assign is_preamble = all_ctl && (ctl_val == CTL_VIDEO_PREAMBLE || ctl_val == CTL_AUXIL_PREAMBLE);
    // A pattern change restarts the run at one: the changed symbol is itself the first of the new run.
    assign pre_cnt_next   = (pre_cnt_reg != '0 && ctl_val == pre_pattern_reg) ? pre_cnt_reg + 1'b1
                                                                              : PRE_W'(1);
    assign guard_cnt_next = guard_cnt_reg + 1'b1;
    assign island_bad     = (island_cnt_reg == '0) || ((island_cnt_reg % PKT_C) != '0);
    assign video_pre_done = symbolValid && state == CONTROL && is_preamble
                            && ctl_val == CTL_VIDEO_PREAMBLE && pre_cnt_next == PRE_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= CONTROL;
            hsync           <= 1'b0;
            vsync           <= 1'b0;
            ctl             <= '0;
            videoData       <= '0;
            videoValid      <= 1'b0;
            auxData         <= '0;
            auxValid        <= 1'b0;
            packetStart     <= 1'b0;
            protocolError   <= 1'b0;
            pre_cnt_reg     <= '0;
            pre_pattern_reg <= '0;
            guard_cnt_reg   <= '0;
            island_cnt_reg  <= '0;
            trailing_reg    <= 1'b0;
        end else begin
            videoValid    <= 1'b0;
            auxValid      <= 1'b0;
            packetStart   <= 1'b0;
            protocolError <= 1'b0;
            if (symbolValid) begin
                case (state)
                    CONTROL: begin
                        if (!all_ctl) begin
                            protocolError <= 1'b1;
                            pre_cnt_reg   <= '0;
                        end else begin
                            {vsync, hsync} <= ctl_code[0];
                            ctl            <= ctl_val;
                            if (is_preamble) begin
                                pre_pattern_reg <= ctl_val;
                                if (pre_cnt_next == PRE_LAST) begin
                                    state       <= (ctl_val == CTL_VIDEO_PREAMBLE) ? VIDEO_PREAMBLE
                                                                                   : AUXIL_PREAMBLE;
                                    pre_cnt_reg <= '0;
                                end else begin
                                    pre_cnt_reg <= pre_cnt_next;
                                end
                            end else begin
                                pre_cnt_reg <= '0;
                            end
                        end
                    end
                    VIDEO_PREAMBLE, AUXIL_PREAMBLE: begin
                        if (all_ctl && ctl_val == pre_pattern_reg) begin
                            {vsync, hsync} <= ctl_code[0];
                            ctl            <= ctl_val;
                        end else if (state == VIDEO_PREAMBLE && all_vguard) begin
                            state         <= VIDEO_GUARD;
                            guard_cnt_reg <= GRD_W'(1);
                        end else if (state == AUXIL_PREAMBLE && all_iguard) begin
                            state          <= AUXIL_GUARD;
                            guard_cnt_reg  <= GRD_W'(1);
                            trailing_reg   <= 1'b0;
                            {vsync, hsync} <= terc4_data[0][1:0];
                        end else begin
                            protocolError <= 1'b1;
                            state         <= CONTROL;
                        end
                    end
                    VIDEO_GUARD: begin
                        if (all_vguard) begin
                            if (guard_cnt_next == GRD_LAST) begin
                                state         <= VIDEO_ISLAND;
                                guard_cnt_reg <= '0;
                            end else begin
                                guard_cnt_reg <= guard_cnt_next;
                            end
                        end else begin
                            protocolError <= 1'b1;
                            state         <= CONTROL;
                            guard_cnt_reg <= '0;
                        end
                    end
                    VIDEO_ISLAND: begin
                        if (any_ctl) begin
                            state          <= CONTROL;
                            {vsync, hsync} <= ctl_code[0];
                            ctl            <= ctl_val;
                        end else begin
                            videoValid <= 1'b1;
                            videoData  <= {tmds_data[2], tmds_data[1], tmds_data[0]};
                        end
                    end
                    AUXIL_GUARD: begin
                        if (all_iguard) begin
                            {vsync, hsync} <= terc4_data[0][1:0];
                            if (guard_cnt_next == GRD_LAST) begin
                                state          <= trailing_reg ? CONTROL : AUXIL_ISLAND;
                                guard_cnt_reg  <= '0;
                                island_cnt_reg <= '0;
                            end else begin
                                guard_cnt_reg <= guard_cnt_next;
                            end
                        end else begin
                            protocolError <= 1'b1;
                            state         <= CONTROL;
                            guard_cnt_reg <= '0;
                        end
                    end
                    AUXIL_ISLAND: begin
                        {vsync, hsync} <= terc4_data[0][1:0];
                        if (trail_guard) begin
                            state         <= AUXIL_GUARD;
                            trailing_reg  <= 1'b1;
                            guard_cnt_reg <= GRD_W'(1);
                            protocolError <= island_bad;
                        end else if (island_cnt_reg == ISL_MAX) begin
                            protocolError <= 1'b1;
                            state         <= CONTROL;
                        end else begin
                            auxValid       <= 1'b1;
                            auxData        <= {terc4_data[2], terc4_data[1], terc4_data[0]};
                            packetStart    <= ((island_cnt_reg % PKT_C) == '0);
                            island_cnt_reg <= island_cnt_reg + 1'b1;
                            protocolError  <= !terc4_ok;
                        end
                    end
                    default: state <= CONTROL;
                endcase
            end
        end
    end

`ifdef HDMI_DECODER_ERROR_COUNT_EN
    // protocolError is already registered, so count the pulse the cycle after it appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errorCount <= '0;
        end else if (video_pre_done) begin
            errorCount <= '0;
        end else if (protocolError && errorCount != 16'hFFFF) begin
            errorCount <= errorCount + 16'd1;
        end
    end
`else
    logic unused_pre_done;
    assign unused_pre_done = video_pre_done;
`endif

endmodule

// File: tb/tb_hdmi_link_decoder.sv
// Directed self-checking bench for hdmi_link_decoder: video frame, data islands,
// framing violations, symbolValid gaps and asynchronous reset.
module tb_hdmi_link_decoder;
    import hdmi_link_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        symbolValid = 1'b0;
    logic [9:0]  symbol0 = '0;
    logic [9:0]  symbol1 = '0;
    logic [9:0]  symbol2 = '0;
    STATE_t      state;
    logic        hsync, vsync;
    logic [3:0]  ctl;
    logic [23:0] videoData;
    logic        videoValid;
    logic [11:0] auxData;
    logic        auxValid;
    logic        packetStart;
    logic        protocolError;
`ifdef HDMI_DECODER_ERROR_COUNT_EN
    logic [15:0] errorCount;
`endif

    int checks = 0;
    int fails = 0;
    int err_pulses = 0;
    int aux_cnt, start_cnt, start_wrong, aux_wrong, stray;

    hdmi_link_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .symbolValid   (symbolValid),
        .symbol0       (symbol0),
        .symbol1       (symbol1),
        .symbol2       (symbol2),
        .state         (state),
        .hsync         (hsync),
        .vsync         (vsync),
        .ctl           (ctl),
        .videoData     (videoData),
        .videoValid    (videoValid),
        .auxData       (auxData),
        .auxValid      (auxValid),
        .packetStart   (packetStart),
        .protocolError (protocolError)
`ifdef HDMI_DECODER_ERROR_COUNT_EN
        ,
        .errorCount    (errorCount)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ctl_tok(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] n);
        case (n)
            4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;  4'hB: return 10'b1011000110;
            4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;  default: return 10'b1011000011;
        endcase
    endfunction

    // Transmit-side TMDS encoding with an explicit choice of XOR/XNOR and inversion.
    function automatic logic [9:0] tmds_enc(input logic [7:0] d, input logic use_xor, input logic inv);
        logic [7:0] qm;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xor ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
        return {inv, use_xor, inv ? ~qm : qm};
    endfunction

    function automatic logic [23:0] pixel(input int k);
        case (k)
            0: return 24'h123456;
            1: return 24'hABCDEF;
            2: return 24'h000000;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    task automatic send(input logic v, input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        @(negedge clk);
        symbolValid = v; symbol0 = a; symbol1 = b; symbol2 = c;
        @(posedge clk);
        #1;
        if (protocolError) err_pulses++;
        $display("t=%0t v=%b sym=%h/%h/%h state=%0d vv=%b vd=%h av=%b ad=%h ps=%b pe=%b",
                 $time, v, a, b, c, state, videoValid, videoData, auxValid, auxData, packetStart, protocolError);
    endtask

    task automatic send_ctl(input logic [3:0] c, input logic [1:0] hv);
        send(1'b1, ctl_tok(hv), ctl_tok(c[1:0]), ctl_tok(c[3:2]));
    endtask

    task automatic send_vguard();
        send(1'b1, 10'b1011001100, 10'b0100110011, 10'b1011001100);
    endtask

    task automatic send_iguard(input logic [1:0] hv);
        send(1'b1, terc4({2'b11, hv}), 10'b0100110011, 10'b0100110011);
    endtask

    task automatic enter_island(input logic [1:0] hv);
        repeat (8) send_ctl(4'b0101, hv);
        repeat (2) send_iguard(hv);
    endtask

    // Drives n island symbols (optionally each followed by an idle cycle) and tallies what came out.
    task automatic drive_island(input int n, input bit gaps);
        logic [3:0] n0, n1, n2;
        aux_cnt = 0; start_cnt = 0; start_wrong = 0; aux_wrong = 0; stray = 0;
        for (int i = 0; i < n; i++) begin
            n0 = 4'(i); n1 = 4'(i >> 4) ^ 4'h5; n2 = ~4'(i);
            send(1'b1, terc4(n0), terc4(n1), terc4(n2));
            if (auxValid) aux_cnt++;
            if (auxData !== {n2, n1, n0}) aux_wrong++;
            if (packetStart) begin
                start_cnt++;
                if (i % 32 != 0) start_wrong++;
            end
            if (gaps) begin
                send(1'b0, terc4(4'h3), terc4(4'h3), terc4(4'h3));
                if (auxValid || packetStart || videoValid) stray++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state !== CONTROL) begin fails++; $display("FAIL reset_state: got %0d want %0d", state, CONTROL); end
        checks++;
        if ({hsync, vsync, ctl, videoData, videoValid, auxData, auxValid, packetStart, protocolError} !== '0) begin
            fails++; $display("FAIL reset_outputs: got vd=%h ad=%h ctl=%h flags=%b want all zero", videoData, auxData, ctl,
                              {hsync, vsync, videoValid, auxValid, packetStart, protocolError});
        end
`ifdef HDMI_DECODER_ERROR_COUNT_EN
        checks++;
        if (errorCount !== 16'd0) begin fails++; $display("FAIL reset_error_count: got %0d want 0", errorCount); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_video_frame();
        logic [23:0] p;
        err_pulses = 0;
        repeat (8) send_ctl(4'b0001, 2'b11);
        checks++;
        if (state !== VIDEO_PREAMBLE) begin fails++; $display("FAIL video_preamble_state: got %0d want %0d", state, VIDEO_PREAMBLE); end
        checks++;
        if (ctl !== 4'b0001 || {vsync, hsync} !== 2'b11) begin
            fails++; $display("FAIL video_preamble_ctl: got ctl=%b vs/hs=%b%b want 0001 11", ctl, vsync, hsync);
        end
        send_vguard();
        checks++;
        if (state !== VIDEO_GUARD) begin fails++; $display("FAIL video_guard1_state: got %0d want %0d", state, VIDEO_GUARD); end
        send_vguard();
        checks++;
        if (state !== VIDEO_ISLAND || videoValid !== 1'b0) begin
            fails++; $display("FAIL video_guard2: got state=%0d vv=%b want %0d 0", state, videoValid, VIDEO_ISLAND);
        end
        for (int k = 0; k < 4; k++) begin
            p = pixel(k);
            send(1'b1, tmds_enc(p[7:0], k[0], k[1]), tmds_enc(p[15:8], k[1], k[0]), tmds_enc(p[23:16], ~k[0], k[1]));
            checks++;
            if (videoValid !== 1'b1 || videoData !== p) begin
                fails++; $display("FAIL video_pixel%0d: got vv=%b data=%h want 1 %h", k, videoValid, videoData, p);
            end
            checks++;
            if ({vsync, hsync} !== 2'b11) begin fails++; $display("FAIL video_sync_hold%0d: got %b%b want 11", k, vsync, hsync); end
        end
        send_ctl(4'b0000, 2'b00);
        checks++;
        if (state !== CONTROL || videoValid !== 1'b0 || hsync !== 1'b0) begin
            fails++; $display("FAIL video_end: got state=%0d vv=%b hs=%b want %0d 0 0", state, videoValid, hsync, CONTROL);
        end
        checks++;
        if (err_pulses !== 0) begin fails++; $display("FAIL video_errors: got %0d want 0", err_pulses); end
    endtask

    task automatic test_data_island();
        err_pulses = 0;
        enter_island(2'b00);
        checks++;
        if (state !== AUXIL_ISLAND) begin fails++; $display("FAIL island_entry_state: got %0d want %0d", state, AUXIL_ISLAND); end
        drive_island(64, 1'b0);
        checks++;
        if (aux_cnt !== 64) begin fails++; $display("FAIL island_aux_count: got %0d want 64", aux_cnt); end
        checks++;
        if (start_cnt !== 2 || start_wrong !== 0) begin
            fails++; $display("FAIL island_packet_start: got %0d (misplaced %0d) want 2 (0)", start_cnt, start_wrong);
        end
        checks++;
        if (aux_wrong !== 0) begin fails++; $display("FAIL island_aux_data: got %0d wrong symbols want 0", aux_wrong); end
        send_iguard(2'b10);
        checks++;
        if (state !== AUXIL_GUARD || auxValid !== 1'b0 || protocolError !== 1'b0) begin
            fails++; $display("FAIL island_trail1: got state=%0d av=%b pe=%b want %0d 0 0", state, auxValid, protocolError, AUXIL_GUARD);
        end
        checks++;
        if ({vsync, hsync} !== 2'b10) begin fails++; $display("FAIL island_guard_sync: got %b%b want 10", vsync, hsync); end
        send_iguard(2'b10);
        checks++;
        if (state !== CONTROL) begin fails++; $display("FAIL island_trail2_state: got %0d want %0d", state, CONTROL); end
        checks++;
        if (err_pulses !== 0) begin fails++; $display("FAIL island_errors: got %0d want 0", err_pulses); end
        checks++;
        if (ctl !== 4'b0101) begin fails++; $display("FAIL island_ctl_hold: got %b want 0101", ctl); end
    endtask

    task automatic test_bad_island();
        err_pulses = 0;
        enter_island(2'b01);
        drive_island(40, 1'b0);
        checks++;
        if (err_pulses !== 0 || aux_cnt !== 40) begin
            fails++; $display("FAIL bad_island_body: got err=%0d aux=%0d want 0 40", err_pulses, aux_cnt);
        end
        send_iguard(2'b01);
        checks++;
        if (protocolError !== 1'b1) begin fails++; $display("FAIL bad_island_error: got %b want 1", protocolError); end
        send_iguard(2'b01);
        checks++;
        if (state !== CONTROL || protocolError !== 1'b0) begin
            fails++; $display("FAIL bad_island_end: got state=%0d pe=%b want %0d 0", state, protocolError, CONTROL);
        end
    endtask

    task automatic test_short_preamble();
        repeat (7) send_ctl(4'b0001, 2'b00);
        checks++;
        if (state !== CONTROL) begin fails++; $display("FAIL short_pre_count: got %0d want %0d", state, CONTROL); end
        send_vguard();
        checks++;
        if (protocolError !== 1'b1 || state !== CONTROL || videoValid !== 1'b0) begin
            fails++; $display("FAIL short_pre_guard: got pe=%b state=%0d vv=%b want 1 %0d 0", protocolError, state, videoValid, CONTROL);
        end
        send(1'b1, tmds_enc(8'h56, 1'b1, 1'b0), tmds_enc(8'h34, 1'b1, 1'b0), tmds_enc(8'h12, 1'b1, 1'b0));
        checks++;
        if (videoValid !== 1'b0) begin fails++; $display("FAIL short_pre_no_video: got %b want 0", videoValid); end
    endtask

    task automatic test_gaps();
        err_pulses = 0;
        enter_island(2'b00);
        drive_island(32, 1'b1);
        checks++;
        if (aux_cnt !== 32 || start_cnt !== 1 || start_wrong !== 0) begin
            fails++; $display("FAIL gaps_packet: got aux=%0d starts=%0d want 32 1", aux_cnt, start_cnt);
        end
        checks++;
        if (stray !== 0 || aux_wrong !== 0) begin
            fails++; $display("FAIL gaps_idle: got stray=%0d wrong=%0d want 0 0", stray, aux_wrong);
        end
        repeat (2) send_iguard(2'b00);
        checks++;
        if (state !== CONTROL || err_pulses !== 0) begin
            fails++; $display("FAIL gaps_end: got state=%0d err=%0d want %0d 0", state, err_pulses, CONTROL);
        end
    endtask

    task automatic test_reset_mid_island();
        enter_island(2'b00);
        drive_island(10, 1'b0);
        @(negedge clk);
        symbolValid = 1'b1; symbol0 = terc4(4'hA); symbol1 = terc4(4'h5); symbol2 = terc4(4'h5);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (state !== CONTROL || auxValid !== 1'b0 || packetStart !== 1'b0) begin
            fails++; $display("FAIL mid_reset_async: got state=%0d av=%b ps=%b want %0d 0 0", state, auxValid, packetStart, CONTROL);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (7) send_ctl(4'b0101, 2'b00);
        checks++;
        if (state !== CONTROL) begin fails++; $display("FAIL mid_reset_precount7: got %0d want %0d", state, CONTROL); end
        send_ctl(4'b0101, 2'b00);
        checks++;
        if (state !== AUXIL_PREAMBLE) begin fails++; $display("FAIL mid_reset_precount8: got %0d want %0d", state, AUXIL_PREAMBLE); end
    endtask

    initial begin
        test_reset();
        test_video_frame();
        test_data_island();
        test_bad_island();
        test_short_preamble();
        test_gaps();
        test_reset_mid_island();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hdmi_link_decoder.md
Name: hdmi_link_decoder

Overview:
- Receive-side counterpart of the per-channel HDMI transmit serializer.
- Takes one parallel 10-bit symbol per TMDS channel (0..2) per pixel clock, already word-aligned by the deserializer.
- Classifies the link period with a state machine (control, preamble, guard, video, data island) and decodes each symbol by the rule for that period: control-token, TMDS 10b->8b or TERC4 10b->4b.
- Sits between the 1:10 deserializers and the video/packet sinks.

Parameters:
- PREAMBLE_LEN, 8, consecutive identical preamble control-token symbols required before a guard band is accepted.
- GUARD_LEN, 2, guard-band symbols per guard period.
- PACKET_LEN, 32, data-island symbols per packet.
- MAX_PACKETS, 18, maximum packets per data island.

Ports:
- clk  input  1  pixel clock.
- rst  input  1  asynchronous, active-high reset.
- symbolValid  input  1  the three symbol inputs are valid this cycle.
- symbol0  input  10  channel 0 encoded symbol.
- symbol1  input  10  channel 1 encoded symbol.
- symbol2  input  10  channel 2 encoded symbol.
- state  output  STATE_t  current link period.
- hsync  output  1  decoded HSYNC.
- vsync  output  1  decoded VSYNC.
- ctl  output  4  decoded CTL3..CTL0 (ch2 code, ch1 code).
- videoData  output  24  {ch2,ch1,ch0} decoded bytes.
- videoValid  output  1  videoData is an active pixel.
- auxData  output  12  {ch2,ch1,ch0} TERC4 nibbles.
- auxValid  output  1  auxData is a data-island symbol.
- packetStart  output  1  first symbol of each 32-symbol packet.
- protocolError  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, immediate, any state): state=CONTROL; all outputs 0; all counters 0.
- All outputs are registered. Latency is 1 clk from a symbolValid=1 cycle.
- symbolValid=0: FSM and counters hold; videoValid, auxValid, packetStart and protocolError are 0 that cycle.
- Control tokens (per channel):
  - 1101010100 -> 00
  - 0010101011 -> 01
  - 0101010100 -> 10
  - 1010101011 -> 11
- TMDS decode:
  - If q[9]=1, invert q[7:0].
  - d[0]=q[0].
  - d[i]=q[i]^q[i-1] if q[8]=1, else ~(q[i]^q[i-1]).
- TERC4 decode: exact inverse of the package TERC4 encoder. A non-member symbol decodes to 0 and raises protocolError.
- Guard bands:
  - Video: ch0 and ch2 = 1011001100, ch1 = 0100110011.
  - Data island: ch1 and ch2 = 0100110011; ch0 = TERC4 of 4'b11xx.
- State machine:
  - CONTROL: all channels must carry control tokens. Video preamble is CTL=0001; data-island preamble is CTL=0101. A preamble counter counts consecutive matching symbols and restarts when the pattern changes. Reaching PREAMBLE_LEN moves to VIDEO_PREAMBLE or AUXIL_PREAMBLE. A non-token symbol pulses protocolError and stays in CONTROL.
  - VIDEO_PREAMBLE / AUXIL_PREAMBLE: stay while the pattern holds. A matching guard band moves to VIDEO_GUARD / AUXIL_GUARD. Any other symbol pulses protocolError and returns to CONTROL.
  - VIDEO_GUARD: requires exactly GUARD_LEN guard symbols, then VIDEO_ISLAND. A short guard pulses protocolError and returns to CONTROL.
  - VIDEO_ISLAND: videoValid=1 on every symbol. The first control token on any channel returns to CONTROL and decodes as control that cycle.
  - AUXIL_GUARD, leading: after GUARD_LEN symbols, go to AUXIL_ISLAND and zero the island symbol counter.
  - AUXIL_ISLAND: auxValid=1; packetStart when counter mod PACKET_LEN = 0. A data-island guard on ch1/ch2 enters the trailing AUXIL_GUARD, distinguished by an internal flag.
  - AUXIL_GUARD, trailing: after GUARD_LEN symbols, return to CONTROL.
- Island length rule: must be a nonzero multiple of PACKET_LEN and at most MAX_PACKETS*PACKET_LEN. A violation pulses protocolError at trailing-guard entry. Exceeding the maximum pulses protocolError and forces CONTROL immediately.
- hsync/vsync source by period:
  - CONTROL and preamble: ch0 control code {vsync,hsync}.
  - Data island and its guards: ch0 TERC4 bits[1:0].
  - Video: hold the last value.
- ctl updates only in CONTROL and preamble periods.

Optional Feature:
- HDMI_DECODER_ERROR_COUNT_EN defined:
  - Adds output errorCount[15:0], reset 0.
  - Increments on each protocolError pulse, saturates at 16'hFFFF.
  - Clears when a video preamble completes.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- HDMIPackage: STATE_t (shared with the transmitter); control-token constants; guard-band constants; functions TMDSDecoder and TERC4Decoder alongside the existing TERC4Encoder.
- One sub-module, hdmi_symbol_classifier: per channel, combinational; flags isControl, isVideoGuard, isIslandGuard, isTerc4 plus the decoded values. Instantiated three times with a CHANNEL parameter.

Test Plan:
- Reset mid-island: assert rst during AUXIL_ISLAND symbol 10 -> state=CONTROL immediately; auxValid=0; counters 0.
- Video frame: 8x CTL=0001, 2 video guards, 4 pixels TMDS-encoded from 24'h123456/ABCDEF/000000/FFFFFF, then control 00 -> videoValid high 4 cycles with exact pixels; state back to CONTROL.
- Data island: 8x CTL=0101, 2 guards, 64 TERC4 symbols, 2 guards -> auxValid 64 cycles; packetStart at symbols 0 and 32; protocolError=0.
- Bad island: same but 40 symbols -> protocolError pulse at trailing guard.
- Short preamble: 7x CTL=0001 then video guard -> protocolError pulse; state CONTROL; no videoValid.
- symbolValid gaps: island with symbolValid toggling 1010 -> 32 valid symbols still yield exactly one packet; no spurious error.
